// File: rtl/apa102_strip_tx.sv
// apa102_strip_tx: APA102 strip frame serialiser with valid/ready pixel fetch.
// Each bit cell is CLK_DIV cycles of sck low (mosi loaded) then CLK_DIV cycles of sck high.
module apa102_strip_tx #(
   parameter int NUM_LEDS = 60,
   parameter int CLK_DIV  = 4,
   parameter int END_BITS = 32,
   parameter int IDX_W    = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
   input  logic             CLK,
   input  logic             my_reset_n,
   input  logic             start,
   input  logic [4:0]       brightness,
   output logic             pix_req,
   input  logic             pix_valid,
   input  logic [23:0]      pix_data,
   output logic [IDX_W-1:0] pix_index,
   output logic             sck,
   output logic             mosi,
   output logic             busy,
   output logic             done
);
   localparam int MAX_BITS = (END_BITS > 32) ? END_BITS : 32;
   localparam int CNT_W    = $clog2(MAX_BITS);
   localparam int DIV_W    = $clog2(2 * CLK_DIV);

   if (NUM_LEDS < 1 || CLK_DIV < 1 || END_BITS < (NUM_LEDS + 1) / 2) begin : g_param_check
      $error("apa102_strip_tx: illegal NUM_LEDS/CLK_DIV/END_BITS");
   end

   typedef enum logic [2:0] {S_IDLE, S_START, S_FETCH, S_LED, S_END, S_DONE} state_t;

   state_t           r_state;
   logic [31:0]      r_sh;
   logic [CNT_W-1:0] r_cnt;
   logic [DIV_W-1:0] r_div;
   logic [4:0]       r_bright;

   logic        w_cell_end, w_half, w_last_bit, w_last_led;
   logic [31:0] w_word;

   assign w_cell_end = r_div == DIV_W'(2 * CLK_DIV - 1);
   assign w_half     = r_div == DIV_W'(CLK_DIV - 1);
   assign w_last_bit = r_cnt == '0;
   assign w_last_led = pix_index == IDX_W'(NUM_LEDS - 1);
   assign w_word     = {3'b111, r_bright, pix_data[7:0], pix_data[15:8], pix_data[23:16]};

   always_ff @(posedge CLK or negedge my_reset_n) begin
      if (!my_reset_n) begin
         r_state   <= S_IDLE;
         r_sh      <= '0;
         r_cnt     <= '0;
         r_div     <= '0;
         r_bright  <= '0;
         pix_req   <= 1'b0;
         pix_index <= '0;
         sck       <= 1'b0;
         mosi      <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         case (r_state)
            S_IDLE: if (start) begin
               r_state   <= S_START;
               r_bright  <= brightness;
               busy      <= 1'b1;
               pix_index <= '0;
               r_sh      <= '0;
               r_cnt     <= CNT_W'(31);
               r_div     <= '0;
               mosi      <= 1'b0;
               sck       <= 1'b0;
            end
            S_FETCH: if (pix_valid) begin
               pix_req <= 1'b0;
               r_state <= S_LED;
               mosi    <= w_word[31];
               r_sh    <= {w_word[30:0], 1'b0};
               r_cnt   <= CNT_W'(31);
               r_div   <= '0;
            end
            S_DONE: r_state <= S_IDLE;
            default: if (!w_cell_end) begin
               r_div <= r_div + 1'b1;
               if (w_half) sck <= 1'b1;
            end else begin
               sck   <= 1'b0;
               r_div <= '0;
               // End-frame bits may outnumber the 32-bit register, so ones are refilled from the bottom.
               if (!w_last_bit) begin
                  mosi  <= r_sh[31];
                  r_sh  <= {r_sh[30:0], r_state == S_END};
                  r_cnt <= r_cnt - 1'b1;
               end else if (r_state == S_END) begin
                  r_state <= S_DONE;
                  mosi    <= 1'b0;
                  done    <= 1'b1;
                  busy    <= 1'b0;
               end else if (r_state == S_LED && w_last_led) begin
                  r_state <= S_END;
                  mosi    <= 1'b1;
                  r_sh    <= '1;
                  r_cnt   <= CNT_W'(END_BITS - 1);
               end else begin
                  r_state <= S_FETCH;
                  pix_req <= 1'b1;
                  if (r_state == S_LED) pix_index <= pix_index + 1'b1;
               end
            end
         endcase
      end
   end
endmodule

// File: tb/tb_apa102_strip_tx.sv
// tb_apa102_strip_tx: two configurations (2 LEDs/div 2 and 1 LED/div 1) checked against a bit-queue frame model.
module tb_apa102_strip_tx;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, start, sel, pv;
   logic [4:0]  br;
   logic [23:0] pd;
   logic        req0, req1, sck0, sck1, mosi0, mosi1, busy0, busy1, done0, done1;
   logic [0:0]  idx0, idx1;
   logic        req, sck, mosi, busy, done;
   logic [0:0]  idx;

   assign req  = sel ? req1 : req0;
   assign sck  = sel ? sck1 : sck0;
   assign mosi = sel ? mosi1 : mosi0;
   assign busy = sel ? busy1 : busy0;
   assign done = sel ? done1 : done0;
   assign idx  = sel ? idx1 : idx0;

   apa102_strip_tx #(.NUM_LEDS(2), .CLK_DIV(2), .END_BITS(32)) u_dut0 (
      .CLK(clk), .my_reset_n(rst_n), .start(start & ~sel), .brightness(br),
      .pix_req(req0), .pix_valid(pv), .pix_data(pd), .pix_index(idx0),
      .sck(sck0), .mosi(mosi0), .busy(busy0), .done(done0));

   apa102_strip_tx #(.NUM_LEDS(1), .CLK_DIV(1), .END_BITS(32)) u_dut1 (
      .CLK(clk), .my_reset_n(rst_n), .start(start & sel), .brightness(br),
      .pix_req(req1), .pix_valid(pv), .pix_data(pd), .pix_index(idx1),
      .sck(sck1), .mosi(mosi1), .busy(busy1), .done(done1));

   int          tests, fails, nl, cd;
   logic [23:0] pix [2];
   bit          q [$];
   logic [31:0] words [$];
   logic [31:0] word;
   int          wcnt, edges, led, dones, hi_len, lo_len, cyc_n, t_first, first_per, stall_left, stall_seen;
   bit          in_frame, lo_fetch, prev_sck, mosi_hi, stall_arm, vrand;
   logic [31:0] exp2 [4];
   logic [31:0] exp1 [3];

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic build();
      logic [31:0] w;
      q.delete();
      for (int i = 0; i < 32; i++) q.push_back(1'b0);
      for (int l = 0; l < nl; l++) begin
         w = {3'b111, br, pix[l][7:0], pix[l][15:8], pix[l][23:16]};
         for (int b = 31; b >= 0; b--) q.push_back(w[b]);
      end
      for (int i = 0; i < 32; i++) q.push_back(1'b1);
      in_frame = 1; led = 0; edges = 0; lo_fetch = 1; words.delete(); wcnt = 0;
      first_per = 0; stall_seen = 0;
   endtask

   task automatic mon();
      cyc_n++;
      if (!rst_n) begin
         chk("reset_outputs", 32'({sck, mosi, req, busy, done, idx}), 32'd0);
         q.delete(); in_frame = 0; prev_sck = 0; hi_len = 0; lo_len = 0; edges = 0;
         return;
      end
      if (sck && !prev_sck) begin
         edges++;
         if (edges == 1) t_first = cyc_n;
         if (edges == 2) first_per = cyc_n - t_first;
         if (q.size() == 0) begin
            tests++; fails++;
            $display("FAIL sck_edge: got edge %0d with no bit expected (t=%0t)", edges, $time);
         end else chk("mosi_bit", 32'(mosi), 32'(q.pop_front()));
         if (!lo_fetch) chk("sck_low_len", 32'(lo_len), 32'(cd));
         word = {word[30:0], mosi};
         wcnt++;
         if (wcnt == 32) begin words.push_back(word); wcnt = 0; end
         mosi_hi = mosi; lo_len = 0; lo_fetch = 0;
      end
      if (sck) begin
         hi_len++;
         chk("mosi_stable_high", 32'(mosi), 32'(mosi_hi));
      end else begin
         if (prev_sck) chk("sck_high_len", 32'(hi_len), 32'(cd));
         hi_len = 0; lo_len++;
      end
      if (req) begin
         chk("req_sck_low", 32'(sck), 32'd0);
         chk("pix_index", 32'(idx), 32'(led));
         lo_fetch = 1;
         if (pv) led++; else stall_seen++;
      end
      chk("busy", 32'(busy), 32'(in_frame && !done));
      if (!in_frame) chk("idle_lines", 32'({sck, mosi}), 32'd0);
      if (done) begin
         dones++;
         chk("done_in_frame", 32'(in_frame), 32'd1);
         chk("done_queue_empty", 32'(q.size()), 32'd0);
         chk("done_edges", 32'(edges), 32'(64 + 32 * nl));
         chk("done_after_fall", 32'(prev_sck), 32'd1);
      end
      if (start && !in_frame) build();
      if (done) in_frame = 0;
      prev_sck = sck;
   endtask

   task automatic drive();
      if (stall_left > 0 && req) begin
         pv = 1'b0; stall_left--;
      end else if (stall_arm && req && idx == 1'b1) begin
         pv = 1'b0; stall_left = 19; stall_arm = 0;
      end else pv = vrand ? ($urandom_range(0, 3) != 0) : 1'b1;
      pd = (req && int'(idx) < nl) ? pix[idx] : 24'($urandom());
   endtask

   task automatic cyc();
      @(negedge clk);
      mon();
      @(posedge clk);
      #1;
      drive();
   endtask

   task automatic wait_done(string name);
      int d0 = dones;
      int n = 0;
      while (dones == d0 && n < 6000) begin cyc(); n++; end
      if (dones == d0) begin
         tests++; fails++;
         $display("FAIL %s_timeout: got no done after %0d cycles, required one", name, n);
      end
      repeat (2) cyc();
   endtask

   task automatic frame(string name);
      start = 1'b1;
      cyc();
      start = 1'b0;
      wait_done(name);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (3) cyc();
      rst_n = 1'b1;
   endtask

   task automatic check_words2(string name);
      chk({name, "_word_count"}, 32'(words.size()), 32'd4);
      for (int i = 0; i < 4; i++)
         chk($sformatf("%s_word%0d", name, i), (words.size() > i) ? words[i] : 32'hDEADBEEF, exp2[i]);
   endtask

   initial begin
      int d0, e0, n;
      tests = 0; fails = 0; cyc_n = 0; dones = 0; stall_left = 0; stall_arm = 0; vrand = 0;
      rst_n = 1'b0; start = 1'b0; sel = 1'b0; pv = 1'b0; pd = '0; br = 5'h1F; nl = 2; cd = 2;
      exp2[0] = 32'h00000000; exp2[1] = 32'hFF0000FF; exp2[2] = 32'hFF00FF00; exp2[3] = 32'hFFFFFFFF;
      exp1[0] = 32'h00000000; exp1[1] = 32'hFF0000FF; exp1[2] = 32'hFFFFFFFF;
      pix[0] = 24'hFF0000; pix[1] = 24'h00FF00;
      #2;
      chk("reset_state", 32'({sck, mosi, req, busy, done, idx}), 32'd0);
      do_reset();

      repeat (1000) cyc();
      chk("idle_no_done", 32'(dones), 32'd0);

      frame("basic");
      chk("basic_edges", 32'(edges), 32'd128);
      chk("basic_period", 32'(first_per), 32'd4);
      chk("basic_dones", 32'(dones), 32'd1);
      chk("basic_busy_after", 32'(busy), 32'd0);
      check_words2("basic");

      stall_arm = 1;
      frame("stall");
      chk("stall_cycles", 32'(stall_seen), 32'd20);
      chk("stall_edges", 32'(edges), 32'd128);
      check_words2("stall");

      d0 = dones;
      start = 1'b1;
      cyc();
      start = 1'b0;
      repeat (100) cyc();
      start = 1'b1; br = 5'h01;
      cyc();
      start = 1'b0;
      wait_done("restart");
      chk("restart_hdr0", 32'((words.size() > 1) ? words[1][31:24] : 8'h00), 32'h000000FF);
      chk("restart_hdr1", 32'((words.size() > 2) ? words[2][31:24] : 8'h00), 32'h000000FF);
      e0 = edges;
      repeat (200) cyc();
      chk("restart_one_frame", 32'(dones - d0), 32'd1);
      chk("restart_no_edges", 32'(edges), 32'(e0));

      br = 5'h1F;
      start = 1'b1;
      cyc();
      start = 1'b0;
      n = 0;
      while (!(edges >= 40 && sck) && n < 2000) begin cyc(); n++; end
      chk("midreset_reached", 32'(sck), 32'd1);
      #1 rst_n = 1'b0;
      #1;
      chk("midreset_sck", 32'(sck), 32'd0);
      chk("midreset_mosi", 32'(mosi), 32'd0);
      chk("midreset_busy", 32'(busy), 32'd0);
      chk("midreset_req", 32'(req), 32'd0);
      repeat (3) cyc();
      rst_n = 1'b1;
      cyc();
      frame("after_reset");
      chk("after_reset_edges", 32'(edges), 32'd128);
      check_words2("after_reset");

      vrand = 1;
      for (int k = 0; k < 6; k++) begin
         pix[0] = 24'($urandom()); pix[1] = 24'($urandom()); br = 5'($urandom());
         frame("rand2");
         chk("rand2_edges", 32'(edges), 32'd128);
      end

      vrand = 0;
      rst_n = 1'b0;
      sel = 1'b1; nl = 1; cd = 1;
      repeat (3) cyc();
      rst_n = 1'b1;
      pix[0] = 24'hFF0000; br = 5'h1F;
      frame("single");
      chk("single_edges", 32'(edges), 32'd96);
      chk("single_period", 32'(first_per), 32'd2);
      chk("single_word_count", 32'(words.size()), 32'd3);
      for (int i = 0; i < 3; i++)
         chk($sformatf("single_word%0d", i), (words.size() > i) ? words[i] : 32'hDEADBEEF, exp1[i]);

      vrand = 1;
      for (int k = 0; k < 4; k++) begin
         pix[0] = 24'($urandom()); br = 5'($urandom());
         frame("rand1");
         chk("rand1_edges", 32'(edges), 32'd96);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
